wave_sequencer: RTL
===================

// Module: wave_sequencer
// PURPOSE
//  Plays a programmed list of waveform segments through WaveGenerator, in order.
//  Each table entry holds a waveform type, frequency word, duty word and dwell time.
//  The block drives wave_sel, freq_ctrl and pulse_duty_cycle, plus an active-high
//  generator reset that restarts the generator phase at every segment boundary.
//  It sits between the host config registers and the WaveGenerator instance.
// PARAMETERS
//  DEPTH    16  number of segment entries in the table
//  ADDR_W    4  table address width; must satisfy 2**ADDR_W >= DEPTH
//  DWELL_W  24  width of the per-segment dwell count, in clk cycles
//  RST_CYC   2  number of cycles gen_rst is held high at each segment start (>=1)
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous reset, active low
//  cfg_wr_en      in   1        write one table entry this cycle
//  cfg_addr       in   ADDR_W   entry index; writes with cfg_addr >= DEPTH are dropped
//  cfg_wave_sel   in   2        entry waveform: 00 nco, 01 chirp, 10 saw, 11 pulse
//  cfg_freq       in   32       entry frequency control word
//  cfg_duty       in   32       entry pulse duty word
//  cfg_dwell      in   DWELL_W  entry dwell in cycles; 0 is treated as 1
//  num_entries    in   ADDR_W+1 active list length, sampled on start
//  loop_en        in   1        1: wrap from the last entry back to entry 0; 0: stop
//  start          in   1        level-sampled; acted on only in IDLE
//  stop           in   1        abort, acted on in any state
//  wave_sel       out  2        to WaveGenerator.wave_sel
//  freq_ctrl      out  32       to WaveGenerator.freq_ctrl
//  pulse_duty     out  32       to WaveGenerator.pulse_duty_cycle
//  gen_rst        out  1        to WaveGenerator.rst, active high
//  busy           out  1        high in every state except IDLE
//  seg_idx        out  ADDR_W   index of the segment currently driven
//  done           out  1        one-cycle pulse when a non-looping list ends
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   - wave_sel=0, freq_ctrl=0, pulse_duty=0, seg_idx=0
//   - gen_rst=1, busy=0, done=0; state=IDLE
//   - the table is not cleared
//  FSM states: IDLE, LOAD, GRST, RUN.
//  IDLE
//   - gen_rst=1; the other outputs hold their last values
//   - start=1 & stop=0 & n!=0 -> LOAD with idx=0
//   - n = min(num_entries, DEPTH); n=0 ignores start
//  LOAD
//   - 1 cycle: synchronous table read of entry idx
//  GRST
//   - entered on the cycle after LOAD
//   - wave_sel, freq_ctrl, pulse_duty and seg_idx are updated on entry
//   - gen_rst=1 for RST_CYC cycles
//   - the dwell counter loads max(dwell,1)
//  RUN
//   - gen_rst=0; the counter decrements each cycle
//   - on the cycle the counter reaches 1: idx<n-1 -> LOAD idx+1
//   - idx=n-1 & loop_en -> LOAD idx=0
//   - idx=n-1 & !loop_en -> IDLE, done=1 for that single cycle
//  Segment period = 1 + RST_CYC + max(dwell,1) cycles.
//  Latency: start sampled at cycle T -> outputs valid and gen_rst high at T+2.
//  stop=1 in any state:
//   - next state is IDLE and gen_rst=1 on the next edge
//   - done is not pulsed
//   - stop has priority over start and over segment advance
//  start while busy is ignored.
//  num_entries and loop_en changes while busy: only loop_en is re-read, at list end.
//  Writes are allowed at all times, including to the active entry.
//   - outputs are registered copies, so a write affects an entry only the next time
//     it is loaded
//   - a write and a LOAD read to the same address in the same cycle returns the old
//     data
//  The dwell counter is DWELL_W bits and unsigned; it has no wrap, since a load
//  always occurs before 0.
// STRUCTURE
//  wave_seq_pkg:
//   - state enum (IDLE, LOAD, GRST, RUN)
//   - seg_entry_t struct {wave_sel[1:0], freq[31:0], duty[31:0], dwell}
//   - constants WAVE_NCO=2'b00, WAVE_CHIRP=2'b01, WAVE_SAW=2'b10, WAVE_PULSE=2'b11
//  Sub-module wave_seq_mem:
//   - DEPTH x seg_entry_t register file
//   - one write port, one synchronous read port, read-before-write
//  The FSM, dwell counter and output registers sit in wave_sequencer.
// TESTING
//  1 Reset:
//    - stimulus: rst_n=0 mid-RUN
//    - response: immediate gen_rst=1, busy=0, all data outputs 0; done never pulses
//  2 Two-entry run, RST_CYC=2, loop_en=0:
//    - stimulus: e0={00,32'h0100_0000,0,5}, e1={11,32'h0200_0000,32'h8000_0000,3}, start
//    - response: wave_sel=00 from T+2 for 8 cycles, then 11 for 6 cycles
//    - response: done high exactly 1 cycle, then busy=0
//  3 Loop:
//    - stimulus: same table, loop_en=1
//    - response: seg_idx sequence 0,1,0,1...; a gen_rst pulse of 2 cycles at every
//      boundary; done never asserts
//  4 Boundaries:
//    - stimulus: dwell=0 entry
//    - response: segment lasts 1+RST_CYC+1 cycles
//    - stimulus: num_entries=0
//    - response: start ignored
//    - stimulus: num_entries=20
//    - response: clamped to 16
//    - stimulus: write to cfg_addr=16 with DEPTH=16 (ADDR_W=5)
//    - response: write dropped
//  5 Stop/start priority:
//    - stimulus: start & stop in the same cycle in IDLE
//    - response: stays IDLE
//    - stimulus: stop during GRST
//    - response: IDLE next cycle, no done
//  6 Live write:
//    - stimulus: write e0.freq=32'h0300_0000 while e0 is in RUN
//    - response: freq_ctrl unchanged until e0 is reloaded on the next loop

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the waveform segment sequencer.
//   seq_state_t  : sequencer FSM states
//   seg_entry_t  : one table entry (waveform, frequency word, duty word, dwell)
//   WAVE_*       : WaveGenerator waveform select codes
//   eff_dwell()  : dwell of 0 is played as 1 cycle
package wave_seq_pkg;

  localparam int SEG_DWELL_W = 24;

  localparam logic [1:0] WAVE_NCO   = 2'b00;
  localparam logic [1:0] WAVE_CHIRP = 2'b01;
  localparam logic [1:0] WAVE_SAW   = 2'b10;
  localparam logic [1:0] WAVE_PULSE = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, GRST, RUN} seq_state_t;

  typedef struct packed {
    logic [1:0]             wave_sel;
    logic [31:0]            freq;
    logic [31:0]            duty;
    logic [SEG_DWELL_W-1:0] dwell;
  } seg_entry_t;

  function automatic logic [SEG_DWELL_W-1:0] eff_dwell(input logic [SEG_DWELL_W-1:0] d);
    return (d == '0) ? SEG_DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/wave_seq_if.sv
// Host configuration write bus for the segment table.
//   wr_en    : write one entry this cycle
//   addr     : entry index (out-of-range writes are dropped by the table)
//   wave_sel : entry waveform select
//   freq     : entry frequency control word
//   duty     : entry pulse duty word
//   dwell    : entry dwell in clk cycles
// master = host side, slave = sequencer side.
interface wave_seq_cfg_if #(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 24
);
  logic               wr_en;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         wave_sel;
  logic [31:0]        freq;
  logic [31:0]        duty;
  logic [DWELL_W-1:0] dwell;

  modport master (output wr_en, addr, wave_sel, freq, duty, dwell);
  modport slave  (input  wr_en, addr, wave_sel, freq, duty, dwell);
endinterface

// File: rtl/wave_seq_mem.sv
// Segment table: DEPTH x seg_entry_t register file, not reset.
//   clk      : system clock
//   wr_en    : write request; dropped when wr_addr >= DEPTH
//   wr_addr  : write index
//   wr_data  : entry to store
//   rd_en    : read request; rd_data updates on the next edge
//   rd_addr  : read index
//   rd_data  : registered read data (old contents on a same-address write)
module wave_seq_mem
  import wave_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  seg_entry_t        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output seg_entry_t        rd_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  seg_entry_t mem [DEPTH];
  logic       wr_ok;
  logic       rd_ok;

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);
  assign rd_ok = rd_en && (int'(rd_addr) < DEPTH);

  // Both ports are non-blocking on the same edge, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    if (rd_ok) rd_data <= mem[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/wave_sequencer.sv
// Plays a programmed list of waveform segments into a WaveGenerator.
//   clk, rst_n  : system clock, async active-low reset
//   cfg         : table write bus (slave)
//   num_entries : list length, clamped to DEPTH, sampled on start
//   loop_en     : wrap to entry 0 at list end (re-read at list end)
//   start, stop : start from IDLE; stop aborts from any state
//   wave_sel, freq_ctrl, pulse_duty : registered generator controls
//   gen_rst     : generator reset, high in IDLE and GRST
//   busy        : high outside IDLE
//   seg_idx     : index of the segment currently driven
//   done        : one-cycle pulse when a non-looping list ends
//
// state | meaning
// IDLE  | waiting for start, generator held in reset
// LOAD  | table read of entry idx in flight
// GRST  | new entry on outputs, generator reset for RST_CYC cycles
// RUN   | generator running, dwell counter counting down
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = SEG_DWELL_W,
  parameter int RST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  wave_seq_cfg_if.slave     cfg,
  input  logic [ADDR_W:0]   num_entries,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [1:0]        wave_sel,
  output logic [31:0]       freq_ctrl,
  output logic [31:0]       pulse_duty,
  output logic              gen_rst,
  output logic              busy,
  output logic [ADDR_W-1:0] seg_idx,
  output logic              done
);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  seq_state_t          state, state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     n_act;
  logic [ADDR_W:0]     n_clamp;
  logic [DWELL_W-1:0]  cnt;
  logic [RC_W-1:0]     rst_cnt;
  logic                last;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  seg_entry_t          wr_data;
  seg_entry_t          rd_data;

  assign wr_data = '{wave_sel: cfg.wave_sel, freq: cfg.freq, duty: cfg.duty,
                     dwell: SEG_DWELL_W'(cfg.dwell)};

  wave_seq_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (cfg.wr_en),
    .wr_addr (cfg.addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign n_clamp = (num_entries > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_entries;
  assign last    = ({1'b0, idx} == (n_act - 1'b1));
  assign gen_rst = (state == IDLE) || (state == GRST);
  assign busy    = (state != IDLE);

  // The read is issued on the transition into LOAD so the entry is ready by the end of LOAD.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = idx;
    unique case (state)
      IDLE: if (start && n_clamp != '0) begin
        state_nxt = LOAD;
        rd_en     = 1'b1;
        rd_addr   = '0;
      end
      LOAD: state_nxt = GRST;
      GRST: if (rst_cnt == '0) state_nxt = RUN;
      RUN: if (cnt == DWELL_W'(1)) begin
        if (!last) begin
          state_nxt = LOAD;
          rd_en     = 1'b1;
          rd_addr   = idx + 1'b1;
        end else if (loop_en) begin
          state_nxt = LOAD;
          rd_en     = 1'b1;
          rd_addr   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
      rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      n_act      <= '0;
      cnt        <= '0;
      rst_cnt    <= '0;
      wave_sel   <= '0;
      freq_ctrl  <= '0;
      pulse_duty <= '0;
      seg_idx    <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      // RUN -> IDLE without stop can only be the natural end of a non-looping list.
      done  <= (state == RUN) && (state_nxt == IDLE) && !stop;
      if (rd_en) idx <= rd_addr;
      if (state == IDLE && state_nxt == LOAD) n_act <= n_clamp;
      if (state == LOAD && state_nxt == GRST) begin
        wave_sel   <= rd_data.wave_sel;
        freq_ctrl  <= rd_data.freq;
        pulse_duty <= rd_data.duty;
        seg_idx    <= idx;
        cnt        <= DWELL_W'(eff_dwell(rd_data.dwell));
        rst_cnt    <= RC_W'(RST_CYC - 1);
      end else if (state == GRST) begin
        if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
